// File: rtl/mem_ctrl_seq.sv
// mem_ctrl_seq -- Moore-style control sequencer for a simple load/store CPU.
//
// Walks a fixed T0..T7 step sequence per instruction:
// - Fetch runs through T0..T2.
// - Address generation runs through T3..T5.
// - LD and ST finish their memory access in T6/T7.
// - LDI completes in T5.
// - Unknown opcodes divert to ILL for one cycle and then return to IDLE.
// Memory accesses stretch by MEM_WAIT extra cycles using a small wait counter.
//
// Parameters:
//   MEM_WAIT        extra wait cycles per memory Read/Write access (0..7)
//   OPW             opcode width
//   OP_LD/LDI/ST    opcode encodings
//
// Ports:
//   clk, clr                        clock, synchronous active-high reset
//   run                             start/continue instruction execution
//   opcode                          opcode field of IR
//   PC_out, Zlo_out, MDR_out, BAout bus drive strobes
//   MAR_rd .. PC_rd                 register load strobes
//   IncPC .. ALU_add                datapath controls
//   state                           current state code
//   done                            instruction complete
//   illegal                         unknown opcode
module mem_ctrl_seq #(
    parameter int MEM_WAIT = 0,
    parameter int OPW      = 5,
    parameter int OP_LD    = 0,
    parameter int OP_LDI   = 1,
    parameter int OP_ST    = 2
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    output logic           PC_out,
    output logic           Zlo_out,
    output logic           MDR_out,
    output logic           BAout,
    output logic           MAR_rd,
    output logic           MDR_rd,
    output logic           IR_rd,
    output logic           Y_rd,
    output logic           Zlo_rd,
    output logic           PC_rd,
    output logic           IncPC,
    output logic           Gra,
    output logic           Grb,
    output logic           Rin,
    output logic           Rout,
    output logic           Read,
    output logic           Write,
    output logic           ALU_add,
    output logic [3:0]     state,
    output logic           done,
    output logic           illegal
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        ILL  = 4'd9
    } state_t;

    localparam logic [2:0]     WAIT_LAST = 3'(MEM_WAIT);
    localparam logic [OPW-1:0] CODE_LD   = OPW'(OP_LD);
    localparam logic [OPW-1:0] CODE_LDI  = OPW'(OP_LDI);
    localparam logic [OPW-1:0] CODE_ST   = OPW'(OP_ST);

    state_t         state_q;
    state_t         state_n;
    logic [2:0]     wait_q;
    logic [2:0]     wait_n;
    logic [OPW-1:0] op_q;

    logic wait_last;
    logic is_ldi;
    logic is_st;
    logic opcode_legal;
    logic end_of_instr;

    // wait_last marks the final cycle of a stretched memory access.
    // Later steps decode the opcode latched during T2, never the live input.
    assign wait_last    = (wait_q == WAIT_LAST);
    assign is_ldi       = (op_q == CODE_LDI);
    assign is_st        = (op_q == CODE_ST);
    assign opcode_legal = (opcode == CODE_LD) || (opcode == CODE_LDI) || (opcode == CODE_ST);

    // State, wait counter and opcode latch; clr overrides any pending wait.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            wait_q  <= 3'd0;
            op_q    <= '0;
        end else begin
            state_q <= state_n;
            wait_q  <= wait_n;
            if (state_q == T2) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state logic.
    // The wait counter only advances while a wait state holds itself,
    // which stops at WAIT_LAST, so it cannot wrap.
    always_comb begin
        state_n      = state_q;
        end_of_instr = 1'b0;
        case (state_q)
            IDLE: if (run) state_n = T0;
            T0:   state_n = T1;
            T1:   if (wait_last) state_n = T2;
            T2:   state_n = opcode_legal ? T3 : ILL;
            T3:   state_n = T4;
            T4:   state_n = T5;
            T5: begin
                if (is_ldi) end_of_instr = 1'b1;
                else        state_n = T6;
            end
            T6:   if (is_st || wait_last) state_n = T7;
            T7: begin
                if (!is_st || wait_last) end_of_instr = 1'b1;
            end
            ILL:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (end_of_instr) begin
            state_n = run ? T0 : IDLE;
        end

        wait_n = 3'd0;
        if ((state_n == state_q) && (state_q != IDLE)) begin
            wait_n = wait_q + 3'd1;
        end
    end

    // Moore output decode: IDLE and ILL leave every datapath control low.
    always_comb begin
        PC_out  = 1'b0;
        Zlo_out = 1'b0;
        MDR_out = 1'b0;
        BAout   = 1'b0;
        MAR_rd  = 1'b0;
        MDR_rd  = 1'b0;
        IR_rd   = 1'b0;
        Y_rd    = 1'b0;
        Zlo_rd  = 1'b0;
        PC_rd   = 1'b0;
        IncPC   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        ALU_add = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            T0: begin
                PC_out = 1'b1;
                MAR_rd = 1'b1;
                IncPC  = 1'b1;
                Zlo_rd = 1'b1;
            end
            T1: begin
                Zlo_out = (wait_q == 3'd0);
                PC_rd   = (wait_q == 3'd0);
                Read    = 1'b1;
                MDR_rd  = wait_last;
            end
            T2: begin
                MDR_out = 1'b1;
                IR_rd   = 1'b1;
            end
            T3: begin
                Grb   = 1'b1;
                BAout = 1'b1;
                Y_rd  = 1'b1;
            end
            T4: begin
                ALU_add = 1'b1;
                Zlo_rd  = 1'b1;
            end
            T5: begin
                Zlo_out = 1'b1;
                if (is_ldi) begin
                    Gra  = 1'b1;
                    Rin  = 1'b1;
                    done = 1'b1;
                end else begin
                    MAR_rd = 1'b1;
                end
            end
            T6: begin
                if (is_st) begin
                    Gra    = 1'b1;
                    Rout   = 1'b1;
                    MDR_rd = 1'b1;
                end else begin
                    Read   = 1'b1;
                    MDR_rd = wait_last;
                end
            end
            T7: begin
                if (is_st) begin
                    Write = 1'b1;
                    done  = wait_last;
                end else begin
                    MDR_out = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    done    = 1'b1;
                end
            end
            ILL: illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// tb_mem_ctrl_seq -- directed bench for mem_ctrl_seq.
//
// Four sequencers with MEM_WAIT = 0..3 share clk, clr, run and opcode.
// Each scenario resets all four and then compares, every cycle, the full
// output bundle of one instance against a hand-computed expected vector.
module tb_mem_ctrl_seq;

    // Bundle bit positions below state[3:0] (bits 23:20).
    localparam logic [19:0] M_DONE = 20'h80000;
    localparam logic [19:0] M_ILL  = 20'h40000;
    localparam logic [19:0] M_PCO  = 20'h20000;
    localparam logic [19:0] M_ZLO  = 20'h10000;
    localparam logic [19:0] M_MDRO = 20'h08000;
    localparam logic [19:0] M_BAO  = 20'h04000;
    localparam logic [19:0] M_ROUT = 20'h02000;
    localparam logic [19:0] M_MARR = 20'h01000;
    localparam logic [19:0] M_MDRR = 20'h00800;
    localparam logic [19:0] M_IRR  = 20'h00400;
    localparam logic [19:0] M_YR   = 20'h00200;
    localparam logic [19:0] M_ZLR  = 20'h00100;
    localparam logic [19:0] M_PCR  = 20'h00080;
    localparam logic [19:0] M_INC  = 20'h00040;
    localparam logic [19:0] M_GRA  = 20'h00020;
    localparam logic [19:0] M_GRB  = 20'h00010;
    localparam logic [19:0] M_RIN  = 20'h00008;
    localparam logic [19:0] M_RD   = 20'h00004;
    localparam logic [19:0] M_WR   = 20'h00002;
    localparam logic [19:0] M_ADD  = 20'h00001;

    // Expected vectors for the steps whose outputs never vary.
    localparam logic [19:0] X_T0 = M_PCO | M_MARR | M_INC | M_ZLR;
    localparam logic [19:0] X_T2 = M_MDRO | M_IRR;
    localparam logic [19:0] X_T3 = M_GRB | M_BAO | M_YR;
    localparam logic [19:0] X_T4 = M_ADD | M_ZLR;

    logic       clk;
    logic       clr;
    logic       run;
    logic [4:0] opcode;
    logic [23:0] obs [4];

    int checks;
    int fails;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gen_dut
            logic PC_out, Zlo_out, MDR_out, BAout;
            logic MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, PC_rd;
            logic IncPC, Gra, Grb, Rin, Rout, Read, Write, ALU_add;
            logic [3:0] state;
            logic done, illegal;

            mem_ctrl_seq #(.MEM_WAIT(g)) dut (
                .clk(clk), .clr(clr), .run(run), .opcode(opcode),
                .PC_out(PC_out), .Zlo_out(Zlo_out), .MDR_out(MDR_out), .BAout(BAout),
                .MAR_rd(MAR_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd),
                .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .IncPC(IncPC), .Gra(Gra),
                .Grb(Grb), .Rin(Rin), .Rout(Rout), .Read(Read), .Write(Write),
                .ALU_add(ALU_add), .state(state), .done(done), .illegal(illegal)
            );

            assign obs[g] = {state, done, illegal, PC_out, Zlo_out, MDR_out, BAout,
                             Rout, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, PC_rd,
                             IncPC, Gra, Grb, Rin, Read, Write, ALU_add};
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs, let one rising edge pass, and settle before sampling.
    task automatic applyStimulus(input logic c, input logic r, input logic [4:0] op);
        clr    = c;
        run    = r;
        opcode = op;
        @(posedge clk);
        #1;
    endtask

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One clock with the current inputs, then compare instance d.
    task automatic expectCycle(input int d, input string tag, input logic [3:0] st,
                               input logic [19:0] m);
        applyStimulus(clr, run, opcode);
        checkOutput(tag, obs[d], {st, m});
    endtask

    task automatic resetAll();
        applyStimulus(1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reset_dut%0d", i), obs[i], 24'h0);
        end
        clr = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        clr    = 1'b1;
        run    = 1'b0;
        opcode = 5'd0;
        applyStimulus(1'b1, 1'b0, 5'd0);

        // LD with no wait states, run held high: back-to-back into T0.
        resetAll();
        run = 1'b1; opcode = 5'd0;
        expectCycle(0, "A_T0", 4'd1, X_T0);
        expectCycle(0, "A_T1", 4'd2, M_ZLO | M_PCR | M_RD | M_MDRR);
        expectCycle(0, "A_T2", 4'd3, X_T2);
        expectCycle(0, "A_T3", 4'd4, X_T3);
        expectCycle(0, "A_T4", 4'd5, X_T4);
        expectCycle(0, "A_T5", 4'd6, M_ZLO | M_MARR);
        expectCycle(0, "A_T6", 4'd7, M_RD | M_MDRR);
        expectCycle(0, "A_T7", 4'd8, M_MDRO | M_GRA | M_RIN | M_DONE);
        expectCycle(0, "A_next_T0", 4'd1, X_T0);

        // LD with MEM_WAIT=2: both memory reads stretch to three cycles.
        resetAll();
        run = 1'b1; opcode = 5'd0;
        expectCycle(2, "B_T0", 4'd1, X_T0);
        expectCycle(2, "B_T1_w0", 4'd2, M_ZLO | M_PCR | M_RD);
        expectCycle(2, "B_T1_w1", 4'd2, M_RD);
        expectCycle(2, "B_T1_w2", 4'd2, M_RD | M_MDRR);
        expectCycle(2, "B_T2", 4'd3, X_T2);
        expectCycle(2, "B_T3", 4'd4, X_T3);
        expectCycle(2, "B_T4", 4'd5, X_T4);
        expectCycle(2, "B_T5", 4'd6, M_ZLO | M_MARR);
        expectCycle(2, "B_T6_w0", 4'd7, M_RD);
        expectCycle(2, "B_T6_w1", 4'd7, M_RD);
        expectCycle(2, "B_T6_w2", 4'd7, M_RD | M_MDRR);
        expectCycle(2, "B_T7", 4'd8, M_MDRO | M_GRA | M_RIN | M_DONE);

        // ST with MEM_WAIT=1, run dropped after T0, opcode changed after latch.
        resetAll();
        run = 1'b1; opcode = 5'd2;
        expectCycle(1, "C_T0", 4'd1, X_T0);
        run = 1'b0;
        expectCycle(1, "C_T1_w0", 4'd2, M_ZLO | M_PCR | M_RD);
        expectCycle(1, "C_T1_w1", 4'd2, M_RD | M_MDRR);
        expectCycle(1, "C_T2", 4'd3, X_T2);
        expectCycle(1, "C_T3", 4'd4, X_T3);
        opcode = 5'd1;
        expectCycle(1, "C_T4", 4'd5, X_T4);
        expectCycle(1, "C_T5", 4'd6, M_ZLO | M_MARR);
        expectCycle(1, "C_T6", 4'd7, M_GRA | M_ROUT | M_MDRR);
        expectCycle(1, "C_T7_w0", 4'd8, M_WR);
        expectCycle(1, "C_T7_w1", 4'd8, M_WR | M_DONE);
        expectCycle(1, "C_idle", 4'd0, 20'h0);

        // LDI completes in T5 and chains straight into the next fetch.
        resetAll();
        run = 1'b1; opcode = 5'd1;
        expectCycle(0, "D_T0", 4'd1, X_T0);
        expectCycle(0, "D_T1", 4'd2, M_ZLO | M_PCR | M_RD | M_MDRR);
        expectCycle(0, "D_T2", 4'd3, X_T2);
        expectCycle(0, "D_T3", 4'd4, X_T3);
        expectCycle(0, "D_T4", 4'd5, X_T4);
        expectCycle(0, "D_T5", 4'd6, M_ZLO | M_GRA | M_RIN | M_DONE);
        expectCycle(0, "D_next_T0", 4'd1, X_T0);

        // Unknown opcode: one ILL cycle, then IDLE even with run high.
        resetAll();
        run = 1'b1; opcode = 5'd31;
        expectCycle(0, "E_T0", 4'd1, X_T0);
        expectCycle(0, "E_T1", 4'd2, M_ZLO | M_PCR | M_RD | M_MDRR);
        expectCycle(0, "E_T2", 4'd3, X_T2);
        expectCycle(0, "E_ILL", 4'd9, M_ILL);
        expectCycle(0, "E_idle", 4'd0, 20'h0);
        expectCycle(0, "E_restart", 4'd1, X_T0);

        // clr in the second T6 wait cycle (MEM_WAIT=3) aborts the read.
        resetAll();
        run = 1'b1; opcode = 5'd0;
        expectCycle(3, "F_T0", 4'd1, X_T0);
        expectCycle(3, "F_T1_w0", 4'd2, M_ZLO | M_PCR | M_RD);
        expectCycle(3, "F_T1_w1", 4'd2, M_RD);
        expectCycle(3, "F_T1_w2", 4'd2, M_RD);
        expectCycle(3, "F_T1_w3", 4'd2, M_RD | M_MDRR);
        expectCycle(3, "F_T2", 4'd3, X_T2);
        expectCycle(3, "F_T3", 4'd4, X_T3);
        expectCycle(3, "F_T4", 4'd5, X_T4);
        expectCycle(3, "F_T5", 4'd6, M_ZLO | M_MARR);
        expectCycle(3, "F_T6_w0", 4'd7, M_RD);
        expectCycle(3, "F_T6_w1", 4'd7, M_RD);
        clr = 1'b1;
        expectCycle(3, "F_clr", 4'd0, 20'h0);
        clr = 1'b0;
        expectCycle(3, "F_restart", 4'd1, X_T0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_seq.md
MEM_CTRL_SEQ -- requirements
Module: mem_ctrl_seq

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, meaning extra wait cycles per memory Read/Write access (legal 0..7).
REQ-002 SHALL have parameter OPW, default 5, meaning opcode width taken from IR[31:32-OPW].
REQ-003 SHALL have parameters OP_LD / OP_LDI / OP_ST, defaults 0 / 1 / 2, meaning opcode encodings.
REQ-004 SHALL have port clk  in  1  system clock; one clock, all state updates on its rising edge.
REQ-005 SHALL have port clr  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port run  in  1  start/continue instruction execution.
REQ-007 SHALL have port opcode  in  OPW  opcode field of IR.
REQ-008 SHALL have ports PC_out, Zlo_out, MDR_out, BAout  out  1 each  bus drive strobes.
REQ-009 SHALL have ports MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, PC_rd  out  1 each  register load strobes.
REQ-010 SHALL have ports IncPC, Gra, Grb, Rin, Rout, Read, Write, ALU_add  out  1 each  datapath controls.
REQ-011 SHALL have ports state  out  4  current state code; done  out  1  instruction complete; illegal  out  1  unknown opcode.

Function
REQ-012 SHALL be a Moore machine: every output a decode of state register and wait counter only.
REQ-013 SHALL use states IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, T7=8, ILL=9; IDLE and ILL drive all datapath outputs 0.
REQ-014 IDLE: run=1 -> T0, else stay.
REQ-015 T0 (1 cycle): PC_out, MAR_rd, IncPC, Zlo_rd = 1.
REQ-016 T1: Zlo_out, PC_rd only in first cycle; Read=1 for MEM_WAIT+1 cycles; MDR_rd=1 only in last of those cycles; then -> T2.
REQ-017 T2 (1 cycle): MDR_out, IR_rd = 1; next state from opcode: LD/LDI/ST -> T3, other -> ILL.
REQ-018 T3 (1 cycle): Grb, BAout, Y_rd = 1 (R0 as base reads 0 via BAout).
REQ-019 T4 (1 cycle): ALU_add, Zlo_rd = 1 (Z = Y + sign-extended C field).
REQ-020 T5 LD/ST: Zlo_out, MAR_rd = 1 -> T6; T5 LDI: Zlo_out, Gra, Rin = 1, done=1 -> end-of-instruction.
REQ-021 T6 LD: Read=1 for MEM_WAIT+1 cycles, MDR_rd=1 in last cycle -> T7; T6 ST: Gra, Rout, MDR_rd = 1 with Read=0 (1 cycle) -> T7.
REQ-022 T7 LD (1 cycle): MDR_out, Gra, Rin, done = 1; T7 ST: Write=1 for MEM_WAIT+1 cycles, done=1 in last cycle.
REQ-023 End-of-instruction: run=1 -> T0 next cycle (back-to-back, no bubble); run=0 -> IDLE.
REQ-024 ILL: illegal=1 for exactly one cycle -> IDLE regardless of run.
REQ-025 Wait counter SHALL be 3 bits, load 0 on entry to each wait state, increment per cycle, exit on count==MEM_WAIT; never wrap.
REQ-026 run sampled only in IDLE and at end-of-instruction; deassertion mid-instruction SHALL NOT abort.
REQ-027 Opcode sampled only in T2 cycle and latched internally; later opcode changes SHALL NOT alter sequence.
REQ-028 Read and Write SHALL never be 1 simultaneously; no two bus drivers (PC_out, Zlo_out, MDR_out, Rout) SHALL be 1 in the same cycle.
REQ-029 state output SHALL equal state code of REQ-013.

Reset
REQ-030 clr=1 at a rising edge SHALL force state=IDLE, wait counter=0, latched opcode=0 on that edge; all outputs 0 the following cycle.
REQ-031 clr SHALL take priority over run and over any in-progress wait count, including mid-Read or mid-Write.
REQ-032 Before the first clr edge, outputs are undefined; the bench SHALL apply clr for at least 1 cycle.

Verification
REQ-033 MEM_WAIT=0, run=1, opcode=0 (LD): states 1,2,3,4,5,6,7,8 over 8 cycles; done=1 in T7 with MDR_out=Gra=Rin=1; then T0.
REQ-034 MEM_WAIT=2, LD: T1 lasts 3 cycles with Read=1, MDR_rd=1 only in third; T6 same; total 12 cycles T0..T7.
REQ-035 MEM_WAIT=1, opcode=2 (ST), run dropped after T0: T6 asserts Gra/Rout/MDR_rd; Write=1 for 2 cycles; done in second; then IDLE.
REQ-036 opcode=1 (LDI): done=1 in T5 with Gra=Rin=Zlo_out=1; no Read after T1; next state T0 (run=1).
REQ-037 opcode=31: T2 -> ILL, illegal=1 one cycle, -> IDLE; all strobes 0 in ILL.
REQ-038 clr=1 during second wait cycle of T6 (MEM_WAIT=3): next cycle state=0, Read=0, MDR_rd=0; run=1 restarts at T0.
